zap_wb_arbiter: RTL and testbench
=================================

ZAP_WB_ARBITER -- requirements
Module: zap_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32'd256: cycles with granted strobe high and no ack before error, legal 2..65535.
REQ-002 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port i_reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have ports i_m0_wb_cyc/i_m1_wb_cyc  input  1 each  Wishbone cycle, master 0 (I-cache zap_cache), master 1 (D-cache zap_cache).
REQ-005 SHALL have ports i_m0_wb_stb/i_m1_wb_stb  input  1 each  strobe.
REQ-006 SHALL have ports i_m0_wb_wen/i_m1_wb_wen  input  1 each  write enable.
REQ-007 SHALL have ports i_m0_wb_sel/i_m1_wb_sel  input  4 each  byte selects.
REQ-008 SHALL have ports i_m0_wb_adr/i_m1_wb_adr  input  32 each  address.
REQ-009 SHALL have ports i_m0_wb_dat/i_m1_wb_dat  input  32 each  write data.
REQ-010 SHALL have ports i_m0_wb_cti/i_m1_wb_cti  input  3 each  cycle type (CTI_CLASSIC, CTI_BURST, CTI_EOB).
REQ-011 SHALL have ports o_m0_wb_ack/o_m1_wb_ack  output  1 each  routed ack.
REQ-012 SHALL have ports o_m0_wb_err/o_m1_wb_err  output  1 each  timeout error pulse.
REQ-013 SHALL have port o_wb_rdat  output  32  read data broadcast to both masters.
REQ-014 SHALL have ports o_wb_cyc, o_wb_stb, o_wb_wen  output  1 each  to external bus.
REQ-015 SHALL have ports o_wb_sel  output  4; o_wb_adr, o_wb_dat  output  32; o_wb_cti  output  3.
REQ-016 SHALL have ports i_wb_dat  input  32, i_wb_ack  input  1  from external bus.
REQ-017 SHALL have port o_grant  output  2  one-hot current owner (bit0 M0, bit1 M1), 00 when idle.

Function
REQ-018 SHALL implement registered FSM states IDLE, GNT0, GNT1 plus registered last_ff (last granted master) and 16-bit timeout counter.
REQ-019 IDLE: only one cyc high -> grant that master next cycle; both high -> grant the master not equal to last_ff; none -> stay.
REQ-020 In IDLE, o_wb_cyc/stb/wen SHALL be 0, sel/adr/dat 0, cti CTI_CLASSIC, both acks 0.
REQ-021 In GNTx, o_wb_cyc/stb/wen/sel/adr/dat/cti SHALL equal master x inputs combinationally (zero-cycle path).
REQ-022 In GNTx, o_mx_wb_ack = i_wb_ack; non-granted master ack and err SHALL be 0.
REQ-023 o_wb_rdat SHALL equal i_wb_dat in all states.
REQ-024 Grant SHALL be held while granted master's cyc is high, including across bursts and classic back-to-back accesses.
REQ-025 Granted cyc low: next state GNTy if other master's cyc high (direct handoff, no idle cycle), else IDLE; last_ff updated to x.
REQ-026 i_wb_ack in IDLE SHALL be ignored (no master ack).
REQ-027 Counter SHALL increment each cycle granted stb high and i_wb_ack low; clear on ack, grant change or stb low.
REQ-028 Counter reaching TIMEOUT-1 with no ack SHALL pulse o_mx_wb_err for exactly one cycle, clear counter, force next state IDLE with last_ff = x.
REQ-029 Ack and timeout in same cycle: ack SHALL win, no err.
REQ-030 Arbitration SHALL never preempt an active cycle; fairness is round-robin at cycle boundaries.

Reset
REQ-031 i_reset high SHALL immediately force IDLE, last_ff = M1 (M0 wins first tie), counter 0, o_grant 00, all outputs at REQ-020 values, errs 0.
REQ-032 Reset asserted mid-burst SHALL drop o_wb_cyc/stb in the same cycle without waiting for ack; first post-reset arbitration follows REQ-019.

Verification
REQ-033 Reset then M0 cyc/stb, adr 0x0000_1000, ack after 2 cycles -> o_grant 01 next cycle, o_wb_adr 0x0000_1000, o_m0_wb_ack only.
REQ-034 Both cyc high from IDLE after reset -> GNT0; M0 drops cyc -> GNT1 next cycle with no idle; then both again -> GNT0.
REQ-035 M1 8-beat burst (CTI_BURST x7, CTI_EOB) while M0 requests -> M1 keeps grant all 8 acks; M0 granted cycle after M1 cyc drops.
REQ-036 TIMEOUT=4, M0 strobes, no ack -> o_m0_wb_err single pulse 3 cycles after grant, state IDLE next; ack on that cycle instead -> ack, no err.
REQ-037 Assert i_reset during M1 write mid-burst -> o_wb_cyc 0 same cycle, o_grant 00; spurious i_wb_ack in IDLE -> no master ack.

Source files
------------

// File: rtl/zap_wb_arbiter.sv
// -----------------------------------------------------------------------------
// zap_wb_arbiter
//
// Two-master Wishbone arbiter. Master 0 is the instruction cache and master 1
// is the data cache. Both share one external Wishbone bus.
//
// Arbitration rules:
//   - An owner keeps the grant for as long as it holds cyc. This covers bursts
//     and classic back-to-back accesses, and an owner is never preempted.
//   - When both masters request at once from idle, the grant goes to the
//     master that did not own the bus last. After reset, master 0 wins the
//     first tie.
//   - When the owner releases cyc and the other master is waiting, the bus
//     passes straight to the other master with no idle cycle in between.
//   - A strobe that waits TIMEOUT cycles without an ack ends the cycle. The
//     owner then sees a one-cycle err pulse. If an ack arrives on that same
//     cycle, the ack is delivered and no err is raised.
//
// The path from the granted master to the external bus is combinational. The
// selected master's signals reach the bus in the same cycle.
//
// Parameters:
//   TIMEOUT      cycles of unacknowledged granted strobe before err (2..65535)
//
// Ports:
//   i_clk        clock; all state changes on the rising edge
//   i_reset      asynchronous active-high reset
//   i_mX_wb_*    Wishbone master-side request inputs (cyc/stb/wen/sel/adr/dat/cti)
//   o_mX_wb_ack  ack routed to master X while it owns the bus
//   o_mX_wb_err  one-cycle timeout error pulse to master X
//   o_wb_rdat    read data, broadcast to both masters
//   o_wb_*       external bus request outputs
//   i_wb_dat     external bus read data
//   i_wb_ack     external bus acknowledge
//   o_grant      one-hot current owner (bit0 = M0, bit1 = M1), 00 when idle
// -----------------------------------------------------------------------------
module zap_wb_arbiter #(
    parameter logic [31:0] TIMEOUT = 32'd256
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_m0_wb_cyc,
    input  logic        i_m0_wb_stb,
    input  logic        i_m0_wb_wen,
    input  logic [3:0]  i_m0_wb_sel,
    input  logic [31:0] i_m0_wb_adr,
    input  logic [31:0] i_m0_wb_dat,
    input  logic [2:0]  i_m0_wb_cti,
    output logic        o_m0_wb_ack,
    output logic        o_m0_wb_err,

    input  logic        i_m1_wb_cyc,
    input  logic        i_m1_wb_stb,
    input  logic        i_m1_wb_wen,
    input  logic [3:0]  i_m1_wb_sel,
    input  logic [31:0] i_m1_wb_adr,
    input  logic [31:0] i_m1_wb_dat,
    input  logic [2:0]  i_m1_wb_cti,
    output logic        o_m1_wb_ack,
    output logic        o_m1_wb_err,

    output logic [31:0] o_wb_rdat,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [2:0]  o_wb_cti,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,

    output logic [1:0]  o_grant
);

    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    // Counter value on which an unacknowledged strobe times out.
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        last_r;        // last granted master: 0 = M0, 1 = M1
    logic        last_nxt_s;
    logic [15:0] cnt_r;         // cycles the granted strobe has waited for ack
    logic [15:0] cnt_nxt_s;
    logic        count_en_s;
    logic        timeout_s;

    // Read data is broadcast without qualification. Each master accepts it
    // only when it receives its own ack.
    assign o_wb_rdat = i_wb_dat;

    // State, last-owner and timeout-counter registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            last_r  <= last_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state, bus multiplexing, ack/err routing and counter update.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        cnt_nxt_s   = 16'd0;
        count_en_s  = 1'b0;
        timeout_s   = 1'b0;
        o_wb_cyc    = 1'b0;
        o_wb_stb    = 1'b0;
        o_wb_wen    = 1'b0;
        o_wb_sel    = 4'd0;
        o_wb_adr    = 32'd0;
        o_wb_dat    = 32'd0;
        o_wb_cti    = CTI_CLASSIC;
        o_m0_wb_ack = 1'b0;
        o_m1_wb_ack = 1'b0;
        o_m0_wb_err = 1'b0;
        o_m1_wb_err = 1'b0;
        o_grant     = 2'b00;

        case (state_r)
            IDLE: begin
                // Acks arriving while idle are spurious and are dropped.
                if (i_m0_wb_cyc && i_m1_wb_cyc) begin
                    state_nxt_s = last_r ? GNT0 : GNT1;
                end else if (i_m0_wb_cyc) begin
                    state_nxt_s = GNT0;
                end else if (i_m1_wb_cyc) begin
                    state_nxt_s = GNT1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            GNT0: begin
                o_grant     = 2'b01;
                o_wb_cyc    = i_m0_wb_cyc;
                o_wb_stb    = i_m0_wb_stb;
                o_wb_wen    = i_m0_wb_wen;
                o_wb_sel    = i_m0_wb_sel;
                o_wb_adr    = i_m0_wb_adr;
                o_wb_dat    = i_m0_wb_dat;
                o_wb_cti    = i_m0_wb_cti;
                o_m0_wb_ack = i_wb_ack;
                count_en_s  = i_m0_wb_cyc && i_m0_wb_stb && !i_wb_ack;
                // A timeout needs the ack to be absent, so an ack on the
                // same cycle always wins.
                timeout_s   = count_en_s && (cnt_r == TO_LAST);
                o_m0_wb_err = timeout_s;
                if (!i_m0_wb_cyc) begin
                    last_nxt_s  = 1'b0;
                    state_nxt_s = i_m1_wb_cyc ? GNT1 : IDLE;
                end else if (timeout_s) begin
                    last_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GNT0;
                end
            end

            GNT1: begin
                o_grant     = 2'b10;
                o_wb_cyc    = i_m1_wb_cyc;
                o_wb_stb    = i_m1_wb_stb;
                o_wb_wen    = i_m1_wb_wen;
                o_wb_sel    = i_m1_wb_sel;
                o_wb_adr    = i_m1_wb_adr;
                o_wb_dat    = i_m1_wb_dat;
                o_wb_cti    = i_m1_wb_cti;
                o_m1_wb_ack = i_wb_ack;
                count_en_s  = i_m1_wb_cyc && i_m1_wb_stb && !i_wb_ack;
                timeout_s   = count_en_s && (cnt_r == TO_LAST);
                o_m1_wb_err = timeout_s;
                if (!i_m1_wb_cyc) begin
                    last_nxt_s  = 1'b1;
                    state_nxt_s = i_m0_wb_cyc ? GNT0 : IDLE;
                end else if (timeout_s) begin
                    last_nxt_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GNT1;
                end
            end

            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // The wait count restarts on any grant change, on an ack, or on a
        // cycle with no strobe. A timeout also changes the grant, so the
        // counter clears on that cycle too.
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = 16'd0;
        end else if (count_en_s) begin
            cnt_nxt_s = cnt_r + 16'd1;
        end else begin
            cnt_nxt_s = 16'd0;
        end
    end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_zap_wb_arbiter
//
// Testbench for zap_wb_arbiter, built with TIMEOUT = 4.
//
// A driver applies stimulus on the falling clock edge. For every cycle it
// pushes the expected DUT outputs, as predicted by a reference model, into a
// scoreboard queue. A separate monitor pops each entry and compares it with
// the DUT outputs.
//
// The reference model tracks the current owner, the last owner and the
// number of cycles spent waiting for an ack.
//
// The test runs directed scenarios first, then randomized traffic. The random
// traffic includes bursts, wait states, spurious acks and mid-run resets.
// -----------------------------------------------------------------------------
module tb_zap_wb_arbiter;

    localparam int         TO      = 4;
    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] BURST   = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

    typedef struct packed {
        logic [1:0]  grant;
        logic [73:0] bus;     // {cyc, stb, wen, sel, adr, dat, cti}
        logic [3:0]  ae;      // {ack0, ack1, err0, err1}
        logic [31:0] rdat;
    } exp_t;

    logic        clk;
    logic        i_reset;
    logic        i_m0_wb_cyc, i_m0_wb_stb, i_m0_wb_wen;
    logic [3:0]  i_m0_wb_sel;
    logic [31:0] i_m0_wb_adr, i_m0_wb_dat;
    logic [2:0]  i_m0_wb_cti;
    logic        o_m0_wb_ack, o_m0_wb_err;
    logic        i_m1_wb_cyc, i_m1_wb_stb, i_m1_wb_wen;
    logic [3:0]  i_m1_wb_sel;
    logic [31:0] i_m1_wb_adr, i_m1_wb_dat;
    logic [2:0]  i_m1_wb_cti;
    logic        o_m1_wb_ack, o_m1_wb_err;
    logic [31:0] o_wb_rdat;
    logic        o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [2:0]  o_wb_cti;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack;
    logic [1:0]  o_grant;

    zap_wb_arbiter #(.TIMEOUT(32'd4)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_m0_wb_cyc(i_m0_wb_cyc), .i_m0_wb_stb(i_m0_wb_stb), .i_m0_wb_wen(i_m0_wb_wen),
        .i_m0_wb_sel(i_m0_wb_sel), .i_m0_wb_adr(i_m0_wb_adr), .i_m0_wb_dat(i_m0_wb_dat),
        .i_m0_wb_cti(i_m0_wb_cti), .o_m0_wb_ack(o_m0_wb_ack), .o_m0_wb_err(o_m0_wb_err),
        .i_m1_wb_cyc(i_m1_wb_cyc), .i_m1_wb_stb(i_m1_wb_stb), .i_m1_wb_wen(i_m1_wb_wen),
        .i_m1_wb_sel(i_m1_wb_sel), .i_m1_wb_adr(i_m1_wb_adr), .i_m1_wb_dat(i_m1_wb_dat),
        .i_m1_wb_cti(i_m1_wb_cti), .o_m1_wb_ack(o_m1_wb_ack), .o_m1_wb_err(o_m1_wb_err),
        .o_wb_rdat(o_wb_rdat),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen),
        .o_wb_sel(o_wb_sel), .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_cti(o_wb_cti),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack),
        .o_grant(o_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus variables for the next cycle.
    logic        rst_v, ack_v;
    logic [31:0] dat_v;
    logic        m_cyc [2], m_stb [2], m_wen [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_adr [2], m_dat [2];
    logic [2:0]  m_cti [2];

    // Reference model state. owner is -1 when the bus is idle.
    int owner, last_owner, waited;
    bit exp_ack [2];
    bit exp_err [2];

    exp_t sb [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Predicts this cycle's outputs from the inputs just applied, pushes the
    // prediction to the scoreboard, then advances the model by one cycle.
    task automatic model_step();
        exp_t e;
        bit   to;
        int   o;
        e          = '0;
        e.rdat     = dat_v;
        exp_ack[0] = 1'b0; exp_ack[1] = 1'b0;
        exp_err[0] = 1'b0; exp_err[1] = 1'b0;
        if (rst_v) begin
            owner = -1; last_owner = 1; waited = 0;
        end else if (owner >= 0) begin
            o          = owner;
            to         = m_cyc[o] && m_stb[o] && !ack_v && (waited == TO - 1);
            e.grant    = (o == 0) ? 2'b01 : 2'b10;
            e.bus      = {m_cyc[o], m_stb[o], m_wen[o], m_sel[o], m_adr[o], m_dat[o], m_cti[o]};
            exp_ack[o] = ack_v;
            exp_err[o] = to;
            if (!m_cyc[o]) begin
                last_owner = o;
                owner      = m_cyc[1 - o] ? 1 - o : -1;
                waited     = 0;
            end else if (to) begin
                last_owner = o;
                owner      = -1;
                waited     = 0;
            end else begin
                waited = (m_stb[o] && !ack_v) ? waited + 1 : 0;
            end
        end else begin
            if (m_cyc[0] && m_cyc[1]) owner = (last_owner == 0) ? 1 : 0;
            else if (m_cyc[0])        owner = 0;
            else if (m_cyc[1])        owner = 1;
            waited = 0;
        end
        e.ae = {exp_ack[0], exp_ack[1], exp_err[0], exp_err[1]};
        sb.push_back(e);
    endtask

    task automatic drive_cycle();
        @(negedge clk);
        i_reset     = rst_v;
        i_wb_ack    = ack_v;
        i_wb_dat    = dat_v;
        i_m0_wb_cyc = m_cyc[0]; i_m0_wb_stb = m_stb[0]; i_m0_wb_wen = m_wen[0];
        i_m0_wb_sel = m_sel[0]; i_m0_wb_adr = m_adr[0]; i_m0_wb_dat = m_dat[0];
        i_m0_wb_cti = m_cti[0];
        i_m1_wb_cyc = m_cyc[1]; i_m1_wb_stb = m_stb[1]; i_m1_wb_wen = m_wen[1];
        i_m1_wb_sel = m_sel[1]; i_m1_wb_adr = m_adr[1]; i_m1_wb_dat = m_dat[1];
        i_m1_wb_cti = m_cti[1];
        #1;
        model_step();
    endtask

    task automatic set_m(input int x, input logic cyc, input logic wen,
                         input logic [31:0] adr, input logic [2:0] cti);
        m_cyc[x] = cyc;
        m_stb[x] = cyc;
        m_wen[x] = wen;
        m_sel[x] = cyc ? 4'hF : 4'h0;
        m_adr[x] = adr;
        m_dat[x] = cyc ? (32'hD000_0000 | adr) : 32'd0;
        m_cti[x] = cti;
    endtask

    task automatic reset_cycle();
        rst_v = 1'b1;
        drive_cycle();
        rst_v = 1'b0;
    endtask

    // Monitor: compares every scoreboard entry with the DUT, away from the
    // active clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("grant", 96'(o_grant), 96'(e.grant));
                chk("bus", 96'({o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_adr, o_wb_dat, o_wb_cti}),
                    96'(e.bus));
                chk("ack_err", 96'({o_m0_wb_ack, o_m1_wb_ack, o_m0_wb_err, o_m1_wb_err}), 96'(e.ae));
                chk("rdat", 96'(o_wb_rdat), 96'(e.rdat));
            end
        end
    end

    // Watchdog: stops the run if the main sequence never finishes.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Random master traffic state.
    bit act [2];
    bit burst [2];
    int beats [2];

    initial begin
        i_reset = 1'b1;
        rst_v   = 1'b1; ack_v = 1'b1; dat_v = 32'h1234_5678;
        for (int x = 0; x < 2; x++) set_m(x, 1'b0, 1'b0, 32'd0, CLASSIC);
        owner = -1; last_owner = 1; waited = 0;

        // Reset state; a spurious ack during reset must not reach either master.
        drive_cycle();
        drive_cycle();
        #1;
        chk("rst_grant", 96'(o_grant), 96'd0);
        chk("rst_cyc", 96'(o_wb_cyc), 96'd0);
        chk("rst_acks", 96'({o_m0_wb_ack, o_m1_wb_ack}), 96'd0);

        // Single M0 access at 0x1000, acked on the third granted cycle.
        rst_v = 1'b0; ack_v = 1'b0;
        set_m(0, 1'b1, 1'b0, 32'h0000_1000, CLASSIC);
        drive_cycle();
        #1 chk("r33_idle", 96'(o_grant), 96'd0);
        drive_cycle();
        #1 chk("r33_grant", 96'(o_grant), 96'h1);
        chk("r33_adr", 96'(o_wb_adr), 96'h1000);
        drive_cycle();
        ack_v = 1'b1;
        drive_cycle();
        #1 chk("r33_ack", 96'({o_m0_wb_ack, o_m1_wb_ack}), 96'h2);
        ack_v = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'd0, CLASSIC);
        drive_cycle();

        // Tie after reset goes to M0, handoff to M1 has no idle cycle, M1 is
        // not preempted, and the grant returns to M0 when M1 releases.
        reset_cycle();
        ack_v = 1'b1;
        set_m(0, 1'b1, 1'b0, 32'h100, CLASSIC);
        set_m(1, 1'b1, 1'b1, 32'h200, CLASSIC);
        drive_cycle();
        drive_cycle();
        #1 chk("r34_tie", 96'(o_grant), 96'h1);
        set_m(0, 1'b0, 1'b0, 32'd0, CLASSIC);
        drive_cycle();
        drive_cycle();
        #1 chk("r34_handoff", 96'(o_grant), 96'h2);
        set_m(0, 1'b1, 1'b0, 32'h104, CLASSIC);
        drive_cycle();
        #1 chk("r34_nopreempt", 96'(o_grant), 96'h2);
        set_m(1, 1'b0, 1'b0, 32'd0, CLASSIC);
        drive_cycle();
        drive_cycle();
        #1 chk("r34_back", 96'(o_grant), 96'h1);
        set_m(0, 1'b0, 1'b0, 32'd0, CLASSIC);
        drive_cycle();

        // An 8-beat M1 burst holds the grant while M0 waits.
        reset_cycle();
        set_m(1, 1'b1, 1'b1, 32'h4000, BURST);
        drive_cycle();
        for (int b = 0; b < 8; b++) begin
            if (b == 1) set_m(0, 1'b1, 1'b0, 32'h500, CLASSIC);
            set_m(1, 1'b1, 1'b1, 32'h4000 + 32'(4 * b), (b == 7) ? EOB : BURST);
            drive_cycle();
            #1 chk("r35_hold", 96'({o_grant, o_m1_wb_ack}), 96'h5);
        end
        set_m(1, 1'b0, 1'b0, 32'd0, CLASSIC);
        drive_cycle();
        drive_cycle();
        #1 chk("r35_m0next", 96'(o_grant), 96'h1);
        set_m(0, 1'b0, 1'b0, 32'd0, CLASSIC);
        drive_cycle();

        // Timeout raises err three cycles after the grant, then the bus goes
        // idle. A second attempt is acked on the timeout cycle, so no err.
        reset_cycle();
        ack_v = 1'b0;
        set_m(0, 1'b1, 1'b0, 32'h600, CLASSIC);
        drive_cycle();
        drive_cycle();
        #1 chk("r36_grant", 96'(o_grant), 96'h1);
        drive_cycle();
        drive_cycle();
        #1 chk("r36_noerr_early", 96'(o_m0_wb_err), 96'd0);
        drive_cycle();
        #1 chk("r36_err", 96'({o_m0_wb_err, o_m1_wb_err}), 96'h2);
        drive_cycle();
        #1 chk("r36_idle", 96'({o_grant, o_m0_wb_err}), 96'd0);
        drive_cycle();
        drive_cycle();
        drive_cycle();
        ack_v = 1'b1;
        drive_cycle();
        #1 chk("r36_ackwins", 96'({o_m0_wb_ack, o_m0_wb_err}), 96'h2);
        set_m(0, 1'b0, 1'b0, 32'd0, CLASSIC);
        drive_cycle();

        // Reset in the middle of an M1 write burst, then a spurious ack while idle.
        reset_cycle();
        ack_v = 1'b1;
        set_m(1, 1'b1, 1'b1, 32'h800, BURST);
        drive_cycle();
        drive_cycle();
        drive_cycle();
        rst_v = 1'b1;
        drive_cycle();
        #1 chk("r37_cyc", 96'({o_wb_cyc, o_wb_stb, o_grant}), 96'd0);
        chk("r37_ack", 96'(o_m1_wb_ack), 96'd0);
        rst_v = 1'b0;
        set_m(1, 1'b0, 1'b0, 32'd0, CLASSIC);
        drive_cycle();
        #1 chk("r37_spurious", 96'({o_m0_wb_ack, o_m1_wb_ack}), 96'd0);

        // Randomized traffic: bursts, classic runs, wait states, spurious acks
        // and periodic resets.
        for (int x = 0; x < 2; x++) begin
            act[x] = 1'b0; burst[x] = 1'b0; beats[x] = 0;
        end
        for (int k = 0; k < 3000; k++) begin
            for (int x = 0; x < 2; x++) begin
                if (!act[x] && ($urandom_range(0, 3) == 0)) begin
                    act[x]   = 1'b1;
                    burst[x] = $urandom_range(0, 1) == 1;
                    beats[x] = burst[x] ? $urandom_range(2, 8) : $urandom_range(1, 3);
                    m_adr[x] = $urandom() & 32'hFFFF_FFFC;
                    m_wen[x] = $urandom_range(0, 1) == 1;
                end
                m_cyc[x] = act[x];
                m_stb[x] = act[x] && ($urandom_range(0, 4) != 0);
                m_sel[x] = act[x] ? 4'($urandom_range(0, 15)) : 4'd0;
                m_dat[x] = act[x] ? $urandom() : 32'd0;
                m_cti[x] = !act[x] ? CLASSIC : !burst[x] ? CLASSIC : (beats[x] > 1) ? BURST : EOB;
                if (!act[x]) begin
                    m_adr[x] = 32'd0;
                    m_wen[x] = 1'b0;
                end
            end
            ack_v = $urandom_range(0, 99) < ((k < 1500) ? 60 : 25);
            dat_v = $urandom();
            rst_v = (k % 400) >= 398;
            drive_cycle();
            for (int x = 0; x < 2; x++) begin
                if (rst_v || exp_err[x]) begin
                    act[x] = 1'b0;
                end else if (act[x] && exp_ack[x] && m_stb[x]) begin
                    beats[x] = beats[x] - 1;
                    m_adr[x] = m_adr[x] + 32'd4;
                    if (beats[x] == 0) act[x] = 1'b0;
                end
            end
        end

        rst_v = 1'b0;
        ack_v = 1'b0;
        for (int x = 0; x < 2; x++) set_m(x, 1'b0, 1'b0, 32'd0, CLASSIC);
        drive_cycle();
        drive_cycle();
        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
